noc_credit_link_sink: RTL

//  Endpoint-side consumer of one router output port. Takes the credit-based flit stream
//  (data/dest/is_tail/send, credit return) and retimes it through NUM_PIPELINE link stages.

---
 rtl/noc_link_pkg.sv | 19 +
 rtl/noc_link_pipe.sv | 50 +++++
 rtl/noc_credit_link_sink.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/noc_link_pkg.sv
// Shared constants, helpers and the flit layout for the credit link sink.
package noc_link_pkg;

  localparam int MAX_NUM_PIPELINE = 4;
  localparam int DEF_FLIT_WIDTH   = 64;
  localparam int DEF_DEST_WIDTH   = 6;

  // Occupancy counter width: must hold the value BUFFER_DEPTH itself.
  function automatic int clog2_depth(input int depth);
    return $clog2(depth + 1);
  endfunction

  typedef struct packed {
    logic                      is_tail;
    logic [DEF_DEST_WIDTH-1:0] dest;
    logic [DEF_FLIT_WIDTH-1:0] data;
  } flit_t;

endpackage

// File: rtl/noc_link_pipe.sv
// Register chain of STAGES flops; bit 0 optionally async-reset, the rest unreset.
module noc_link_pipe #(
  parameter int WIDTH     = 1,
  parameter int STAGES    = 0,
  parameter bit RESET_LSB = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  if (STAGES == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign q_o = d_i;
  end else begin : g_regs
    logic lsb_q [STAGES];

    if (RESET_LSB) begin : g_lsb_rst
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          lsb_q <= '{default: 1'b0};
        end else begin
          lsb_q[0] <= d_i[0];
          for (int i = 1; i < STAGES; i++) lsb_q[i] <= lsb_q[i-1];
        end
      end
    end else begin : g_lsb_plain
      logic unused_rst;
      assign unused_rst = rst;
      always_ff @(posedge clk) begin
        lsb_q[0] <= d_i[0];
        for (int i = 1; i < STAGES; i++) lsb_q[i] <= lsb_q[i-1];
      end
    end

    if (WIDTH > 1) begin : g_hi
      logic [WIDTH-1:1] hi_q [STAGES];
      always_ff @(posedge clk) begin
        hi_q[0] <= d_i[WIDTH-1:1];
        for (int i = 1; i < STAGES; i++) hi_q[i] <= hi_q[i-1];
      end
      assign q_o = {hi_q[STAGES-1], lsb_q[STAGES-1]};
    end else begin : g_lsb_only
      assign q_o[0] = lsb_q[STAGES-1];
    end
  end

endmodule

// File: rtl/noc_credit_link_sink.sv
// Credit-based flit sink: retiming pipe, show-ahead FIFO, valid/ready output, credit return.
// Optional overflow flag and assertion under NOC_LINK_OVERFLOW_CHECK_EN.
module noc_credit_link_sink
  import noc_link_pkg::*;
#(
  parameter int FLIT_WIDTH   = 64,
  parameter int DEST_WIDTH   = 6,
  parameter int BUFFER_DEPTH = 4,
  parameter int NUM_PIPELINE = 0,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [FLIT_WIDTH-1:0] data_in,
  input  logic [DEST_WIDTH-1:0] dest_in,
  input  logic                  is_tail_in,
  input  logic                  send_in,
  output logic                  credit_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [FLIT_WIDTH-1:0] out_data,
  output logic [DEST_WIDTH-1:0] out_dest,
  output logic                  out_last,
  output logic [CNT_WIDTH-1:0]  pkt_count
`ifdef NOC_LINK_OVERFLOW_CHECK_EN
  , output logic                err_overflow
`endif
);

  if (BUFFER_DEPTH < 2 || NUM_PIPELINE < 0 || NUM_PIPELINE > MAX_NUM_PIPELINE) begin : g_bad_cfg
    $error("noc_credit_link_sink: unsupported BUFFER_DEPTH or NUM_PIPELINE");
  end

  localparam int OCC_W = clog2_depth(BUFFER_DEPTH);
  localparam int PTR_W = $clog2(BUFFER_DEPTH);
  localparam int FWD_W = FLIT_WIDTH + DEST_WIDTH + 2;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(BUFFER_DEPTH - 1);
  localparam logic [OCC_W-1:0] FULL_CNT = OCC_W'(BUFFER_DEPTH);

  typedef struct packed {
    logic                  is_tail;
    logic [DEST_WIDTH-1:0] dest;
    logic [FLIT_WIDTH-1:0] data;
  } link_flit_t;

  logic [FWD_W-1:0] fwd_d, fwd_q;
  link_flit_t       push_flit, head;
  logic             push, pop, full, accept;

  assign fwd_d = {data_in, dest_in, is_tail_in, send_in};

  noc_link_pipe #(.WIDTH(FWD_W), .STAGES(NUM_PIPELINE), .RESET_LSB(1'b1)) u_fwd_pipe (
    .clk (clk),
    .rst (rst),
    .d_i (fwd_d),
    .q_o (fwd_q)
  );

  assign push              = fwd_q[0];
  assign push_flit.is_tail = fwd_q[1];
  assign push_flit.dest    = fwd_q[2 +: DEST_WIDTH];
  assign push_flit.data    = fwd_q[2 + DEST_WIDTH +: FLIT_WIDTH];

  link_flit_t           mem [BUFFER_DEPTH];
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [OCC_W-1:0]     count_q, count_d;
  logic [CNT_WIDTH-1:0] pkt_count_q, pkt_count_d;
  logic                 credit_q;

  // Explicit wrap so non-power-of-2 depths never index past the last entry.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_IDX) ? '0 : p + 1'b1;
  endfunction

  // Output handshake: a flit transfers on any cycle with out_valid & out_ready;
  // out_valid never drops and out_* never change until that transfer happens.
  assign head      = mem[rd_ptr_q];
  assign out_valid = (count_q != '0);
  assign full      = (count_q == FULL_CNT);
  assign pop       = out_valid & out_ready;
  assign accept    = push & (~full | pop);
  assign out_data  = head.data;
  assign out_dest  = head.dest;
  assign out_last  = out_valid & head.is_tail;
  assign pkt_count = pkt_count_q;

  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    pkt_count_d = pkt_count_q;
    if (pop)    rd_ptr_d = ptr_inc(rd_ptr_q);
    if (accept) wr_ptr_d = ptr_inc(wr_ptr_q);
    case ({accept, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (pop && head.is_tail) pkt_count_d = pkt_count_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      pkt_count_q <= '0;
      credit_q    <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      pkt_count_q <= pkt_count_d;
      credit_q    <= pop;
    end
  end

  // When full, a push with a pop writes into the slot the pop frees (wr_ptr == rd_ptr).
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr_q] <= push_flit;
  end

  noc_link_pipe #(.WIDTH(1), .STAGES(NUM_PIPELINE), .RESET_LSB(1'b1)) u_credit_pipe (
    .clk (clk),
    .rst (rst),
    .d_i (credit_q),
    .q_o (credit_out)
  );

`ifdef NOC_LINK_OVERFLOW_CHECK_EN
  logic drop;
  logic err_overflow_q;

  assign drop = push & full & ~pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       err_overflow_q <= 1'b0;
    else if (drop) err_overflow_q <= 1'b1;
  end

  assign err_overflow = err_overflow_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !drop)
    else $error("noc_credit_link_sink: push while full, flit dropped");
`endif

endmodule
